stall_pipeline: RTL and testbench
=================================

Name: stall_pipeline

Overview:
- Parametrised successor to the fixed 3-stage non-stalling register pipeline: DEPTH stages of WIDTH-bit data, each stage carrying a valid bit.
- Adds a valid/ready handshake at both ends, backpressure propagation, bubble collapsing, synchronous flush and an occupancy count.
- Drops into any datapath that needs registered delay under downstream stall without losing or duplicating data.

Parameters:
- WIDTH, 100, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- CNT_W, $clog2(DEPTH+1), width of occupancy output (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stages (active-high).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  pipeline accepts in_data this cycle.
- in_data  in  WIDTH  input payload.
- out_valid  out  1  out_data holds a valid item (last stage valid).
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  last-stage payload.
- occupancy  out  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Stage k (0..DEPTH-1) holds data[k] and valid[k]. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Transfer at the input: in_valid & in_ready. Transfer at the output: out_valid & out_ready.
- Per-stage ready, combinational:
  - rdy[DEPTH-1] = ~valid[DEPTH-1] | out_ready.
  - rdy[k] = ~valid[k] | rdy[k+1].
  - in_ready = rdy[0].
  - The combinational path out_ready -> in_ready is intentional; no registered skid in this block.
- Stage update on each clk edge when rst=0 and flush=0:
  - If rdy[k], stage k loads from its predecessor: valid[k] <= upstream valid (in_valid for k=0), and data[k] <= upstream data.
  - Otherwise stage k holds.
  - Bubble collapsing: an empty stage loads even while downstream stages are stalled.
- Data registers load only when rdy[k] & upstream valid; a bubble moving in leaves data[k] unchanged. out_data is don't-care when out_valid=0, but must be deterministic.
- Latency: with out_ready held 1, an item accepted at edge t appears with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles of delay through DEPTH registers. Throughput is 1 item/cycle.
- Full: all DEPTH valid and out_ready=0 -> in_ready=0, all stages hold, out_data stable.
- Full with out_ready=1: accept and emit in the same cycle; occupancy unchanged.
- occupancy is registered and counts set valid bits. Next value = current + input transfer - output transfer, never exceeding DEPTH.
- flush=1 at an edge:
  - All valid bits clear and occupancy goes to 0.
  - Data registers hold their values.
  - A coincident input transfer is dropped.
  - in_ready still follows the combinational rule during the flush cycle, so the upstream sees its item as consumed.
  - A coincident output transfer completes (downstream took it).
- rst=1 at an edge:
  - All valid bits go to 0, all data registers go to 0, occupancy goes to 0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1.
  - Reset outranks flush. Reset mid-stream discards all in-flight items.
- DEPTH=1 is legal: a single register stage with the same rules.
- No X propagation from data into control: valid bits depend only on handshakes, flush and rst.

Test Plan:
- Streaming, DEPTH=3, WIDTH=100, out_ready=1, push 1,2,3,4 on consecutive cycles -> out_valid rises 3 cycles after the first accept; outputs 1,2,3,4 consecutively; in_ready constant 1; occupancy settles at 3.
- Backpressure: fill with 0xA,0xB,0xC, then out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data=0xA stable, occupancy=3. Release -> 0xA,0xB,0xC then next item emitted in order, no loss or duplication.
- Bubble collapse: push 0x1, idle 2 cycles, push 0x2, with out_ready=0 from start -> both items pack into stages 2 and 1; occupancy=2; in_ready stays 1 until 3 items are held.
- Simultaneous accept/emit when full with out_ready=1 and in_valid=1 -> in_ready=1, occupancy stays 3, order preserved.
- Flush with 2 items held and in_valid=1 on the flush edge -> next cycle out_valid=0, occupancy=0; the flush-cycle input never appears at the output.
- Reset mid-operation with 3 items held and out_ready toggling -> after the edge out_valid=0, out_data=0, occupancy=0, in_ready=1; repeat the streaming scenario with DEPTH=1 (latency 1).

Source files
------------

// File: rtl/stall_pipeline_if.sv
// Valid/ready stream bundle for stall_pipeline: input side, output side and occupancy.
// master = the environment around the pipeline, slave = the pipeline itself.
interface stall_pipeline_if #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 3
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/stall_pipeline.sv
// DEPTH-stage valid/ready register pipeline with backpressure, bubble collapsing,
// synchronous flush and a registered occupancy count.
module stall_pipeline #(
    parameter  int WIDTH = 100,
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    stall_pipeline_if.slave  bus
);
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] up_data  [DEPTH];
    logic [CNT_W-1:0] occ;
    logic             in_xfer;
    logic             out_xfer;

    // Ready ripples back from out_ready; a stage is free if it is empty or the one after it is.
    always_comb begin
        logic r;
        r   = bus.out_ready;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r      = ~valid[k] | r;
            rdy[k] = r;
        end
    end

    always_comb begin
        up_valid[0] = bus.in_valid;
        up_data[0]  = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid[k] = valid[k-1];
            up_data[k]  = data[k-1];
        end
    end

    assign in_xfer  = bus.in_valid & rdy[0];
    assign out_xfer = valid[DEPTH-1] & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            occ   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
            occ   <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid[k] <= up_valid[k];
                    // Bubbles leave the payload untouched so out_data stays deterministic.
                    if (up_valid[k]) begin
                        data[k] <= up_data[k];
                    end
                end
            end
            occ <= occ + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = valid[DEPTH-1];
    assign bus.out_data  = data[DEPTH-1];
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_stall_pipeline.sv
// Drives a DEPTH=3 and a DEPTH=1 stall_pipeline in lockstep and compares both
// against a queue-of-items reference model that tracks each item's stage position.
module tb_stall_pipeline;
    localparam int WIDTH = 100;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               pos;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    int checks = 0;
    int errors = 0;

    item_t mq[2][$];
    int    dep[2] = '{3, 1};
    bit    checking = 1'b0;
    bit    rst_seen = 1'b0;

    stall_pipeline_if #(.WIDTH(WIDTH), .DEPTH(3)) bus3 ();
    stall_pipeline_if #(.WIDTH(WIDTH), .DEPTH(1)) bus1 ();

    stall_pipeline #(.WIDTH(WIDTH), .DEPTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus3)
    );

    stall_pipeline #(.WIDTH(WIDTH), .DEPTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs follow from which items exist and where the oldest one sits.
    task automatic expect_out(input int m, input bit ordy, output bit v, output logic [WIDTH-1:0] d,
                              output int occ, output bit ir);
        v   = (mq[m].size() > 0) && (mq[m][0].pos == dep[m] - 1);
        d   = v ? mq[m][0].d : '0;
        occ = mq[m].size();
        ir  = (mq[m].size() < dep[m]) || ordy;
    endtask

    task automatic model_step(input int m, input bit iv, input logic [WIDTH-1:0] id,
                              input bit ordy, input bit fl, input bit rs);
        int  dd;
        bit  irdy;
        int  lim;
        item_t it;
        dd   = dep[m];
        irdy = (mq[m].size() < dd) || ordy;
        if (rs || fl) begin
            mq[m].delete();
            return;
        end
        if (ordy && mq[m].size() > 0 && mq[m][0].pos == dd - 1) begin
            void'(mq[m].pop_front());
        end
        // Each item advances one stage unless the item ahead of it still occupies that stage.
        for (int i = 0; i < mq[m].size(); i++) begin
            lim = (i == 0) ? dd - 1 : mq[m][i-1].pos - 1;
            if (mq[m][i].pos < lim) mq[m][i].pos = mq[m][i].pos + 1;
        end
        if (iv && irdy) begin
            it.d   = id;
            it.pos = 0;
            mq[m].push_back(it);
        end
    endtask

    task automatic cycle(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                         input bit fl, input bit rs);
        bit               v;
        logic [WIDTH-1:0] d;
        int               occ;
        bit               ir;
        @(negedge clk);
        rst            = rs;
        flush          = fl;
        bus3.in_valid  = iv;
        bus3.in_data   = id;
        bus3.out_ready = ordy;
        bus1.in_valid  = iv;
        bus1.in_data   = id;
        bus1.out_ready = ordy;
        #1;
        if (checking) begin
            expect_out(0, ordy, v, d, occ, ir);
            check("in_ready3", 128'(bus3.in_ready), 128'(ir));
            check("out_valid3", 128'(bus3.out_valid), 128'(v));
            check("occupancy3", 128'(bus3.occupancy), 128'(occ));
            if (v) check("out_data3", 128'(bus3.out_data), 128'(d));
            expect_out(1, ordy, v, d, occ, ir);
            check("in_ready1", 128'(bus1.in_ready), 128'(ir));
            check("out_valid1", 128'(bus1.out_valid), 128'(v));
            check("occupancy1", 128'(bus1.occupancy), 128'(occ));
            if (v) check("out_data1", 128'(bus1.out_data), 128'(d));
            if (rst_seen) begin
                check("rst_out_data3", 128'(bus3.out_data), 128'(0));
                check("rst_out_data1", 128'(bus1.out_data), 128'(0));
            end
        end
        rst_seen = rs;
        model_step(0, iv, id, ordy, fl, rs);
        model_step(1, iv, id, ordy, fl, rs);
        checking = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // streaming
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 1, 0, 0);
        repeat (4) cycle(0, 0, 1, 0, 0);

        // backpressure
        cycle(1, 'hA, 0, 0, 0);
        cycle(1, 'hB, 0, 0, 0);
        cycle(1, 'hC, 0, 0, 0);
        repeat (5) cycle(1, 'hD, 0, 0, 0);
        repeat (2) cycle(1, 'hD, 1, 0, 0);
        repeat (5) cycle(0, 0, 1, 0, 0);

        // bubble collapse
        cycle(1, 'h1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 'h2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 'h3, 0, 0, 0);
        repeat (2) cycle(1, 'h4, 0, 0, 0);

        // simultaneous accept/emit when full
        for (int i = 5; i <= 8; i++) cycle(1, WIDTH'(i), 1, 0, 0);
        repeat (4) cycle(0, 0, 1, 0, 0);

        // flush with items held and a coincident offer
        cycle(1, 'h11, 0, 0, 0);
        cycle(1, 'h22, 0, 0, 0);
        cycle(1, 'h33, 0, 1, 0);
        repeat (4) cycle(0, 0, 1, 0, 0);

        // reset mid-operation
        cycle(1, 'h41, 0, 0, 0);
        cycle(1, 'h42, 0, 0, 0);
        cycle(1, 'h43, 0, 0, 0);
        cycle(1, 'h44, 1, 0, 0);
        cycle(1, 'h45, 0, 0, 0);
        cycle(1, 'h46, 1, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 1, 0, 0);
        repeat (4) cycle(0, 0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), rnd_data(), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
        end
        repeat (4) cycle(0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
